// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared reset PC, bubble word and F-stage FSM encodings for the fetch unit.
package fetch_unit_pkg;
  localparam logic [31:0] FU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FU_NOP_INSTR = 32'h0000_0000;
  typedef enum logic {FS_REQ = 1'b0, FS_BUF = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_unit_fd_reg.sv
// fetch_unit_fd_reg: F/D pipeline register; loads a full D-stage entry when enabled, else holds.
module fetch_unit_fd_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_valid,
  input  logic        i_exc,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid,
  output logic        o_exc
);
  logic [31:0] r_pc, r_instr;
  logic        r_valid, r_exc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_exc   <= 1'b0;
    end else if (i_en) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= i_valid;
      r_exc   <= i_exc;
    end
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;
  assign o_exc   = r_exc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: F-stage PC, req/ready instruction fetch with one-entry skid buffer, F/D register.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PC_F skips the fetch and sends an address-error bubble to D.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FU_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic [31:0] instr_D,
  output logic        valid_D,
  output logic        fetch_busy,
  output logic        exc_adel_D
);
  fetch_state_e r_state, w_next_state;
  logic [31:0]  r_pc_f, r_buf_pc, r_buf_instr;
  logic [31:0]  w_fd_pc, w_fd_instr;
  logic         w_fd_en, w_fd_valid, w_fd_exc, w_pc_adv, w_buf_ld, w_misal;
`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misal = r_pc_f[1:0] != 2'b00;
`else
  assign w_misal = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= FS_REQ;
      r_pc_f      <= RESET_PC;
      r_buf_pc    <= '0;
      r_buf_instr <= NOP_INSTR;
    end else begin
      r_state <= w_next_state;
      if (w_pc_adv) r_pc_f <= next_pc;
      if (w_buf_ld) begin
        r_buf_pc    <= r_pc_f;
        r_buf_instr <= imem_rdata;
      end
    end
  // PC_F only advances when an instruction (or error bubble) enters D, keeping next_pc in step with PC_D.
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    fetch_busy   = 1'b0;
    w_fd_en      = 1'b0;
    w_fd_pc      = r_pc_f;
    w_fd_instr   = NOP_INSTR;
    w_fd_valid   = 1'b0;
    w_fd_exc     = 1'b0;
    w_pc_adv     = 1'b0;
    w_buf_ld     = 1'b0;
    if (r_state == FS_BUF) begin
      w_fd_en      = !stall;
      w_fd_pc      = r_buf_pc;
      w_fd_instr   = r_buf_instr;
      w_fd_valid   = 1'b1;
      w_pc_adv     = !stall;
      w_next_state = stall ? FS_BUF : FS_REQ;
    end else if (w_misal) begin
      w_fd_en    = !stall;
      w_fd_valid = 1'b1;
      w_fd_exc   = 1'b1;
      w_pc_adv   = !stall;
    end else begin
      imem_req     = 1'b1;
      fetch_busy   = !imem_ready;
      w_fd_en      = !stall;
      w_fd_instr   = imem_ready ? imem_rdata : NOP_INSTR;
      w_fd_valid   = imem_ready;
      w_pc_adv     = imem_ready && !stall;
      w_buf_ld     = imem_ready && stall;
      w_next_state = (imem_ready && stall) ? FS_BUF : FS_REQ;
    end
  end
  fetch_unit_fd_reg #(.NOP_INSTR(NOP_INSTR)) u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_fd_en),
    .i_pc    (w_fd_pc),
    .i_instr (w_fd_instr),
    .i_valid (w_fd_valid),
    .i_exc   (w_fd_exc),
    .o_pc    (PC_D),
    .o_instr (instr_D),
    .o_valid (valid_D),
    .o_exc   (exc_adel_D)
  );
  assign PC_F      = r_pc_f;
  assign imem_addr = r_pc_f;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer end of the next-PC path: owns the F-stage PC register and the F/D pipeline register.
- Issues instruction fetches to a variable-latency instruction memory over a req/ready handshake.
- Each cycle, takes the combinationally computed next PC from the D-stage next-PC logic.
- Presents PC_D/instr_D to decode; honours the hazard unit's stall.

Parameters:
- RESET_PC, 32'h0000_3000, PC_F value after reset (first fetch address).
- NOP_INSTR, 32'h0000_0000, instruction word injected into D for bubbles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit stall; holds PC_F and the F/D register
- next_pc  in  32  next PC from the next-PC logic (computed from PC_F/PC_D)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= PC_F)
- imem_ready  in  1  memory accepted the request and imem_rdata is valid this cycle
- imem_rdata  in  32  fetched instruction word
- PC_F  out  32  current fetch PC
- PC_D  out  32  PC of the instruction in D
- instr_D  out  32  instruction in D
- valid_D  out  1  instr_D is a real instruction (0 = bubble)
- fetch_busy  out  1  F-stage waiting on memory (informational to hazard unit)
- exc_adel_D  out  1  D instruction carries a fetch address error (optional feature only)

Behaviour:
- Reset (async, any state, including mid-fetch):
  - PC_F=RESET_PC, PC_D=0, instr_D=NOP_INSTR, valid_D=0, exc_adel_D=0.
  - Skid buffer cleared; state=REQ.
  - A memory response arriving during reset is discarded.
- FSM states: REQ, BUF.
- REQ:
  - imem_req=1, imem_addr=PC_F, fetch_busy=!imem_ready.
  - imem_ready & !stall: at the clock edge PC_D<=PC_F, instr_D<=imem_rdata, valid_D<=1, PC_F<=next_pc; stay REQ.
  - imem_ready & stall: imem_rdata and PC_F go into the skid buffer; F/D and PC_F hold; go BUF.
  - !imem_ready & !stall: bubble into D (instr_D<=NOP_INSTR, valid_D<=0, PC_D<=PC_F); PC_F holds; stay REQ.
  - !imem_ready & stall: everything holds.
- BUF:
  - imem_req=0, fetch_busy=0.
  - !stall: PC_D<=buffered PC, instr_D<=buffered word, valid_D<=1, PC_F<=next_pc; go REQ.
  - stall: hold in BUF.
- Latency: 1-cycle memory → one instruction per cycle into D. N-cycle memory → N-1 bubbles per instruction.
- PC_F advances only when an instruction enters D, so next_pc is always sampled with the correct PC_D (delay slot preserved).
- No flush input: the ISA uses branch delay slots.
- Widths: all PCs are 32-bit; no wrap checking; PC_F simply takes next_pc.
- imem_addr is driven combinationally from PC_F and is stable while imem_req=1.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In REQ with PC_F[1:0]!=0, no request is issued (imem_req=0).
  - When !stall, D receives instr_D=NOP_INSTR, valid_D=1, exc_adel_D=1, PC_D=PC_F.
  - PC_F<=next_pc.
- Undefined: exc_adel_D tied 0; misaligned addresses are fetched unchanged.

Decomposition:
- Shared macros include: RESET_PC value, NOP_INSTR, FSM state encodings (FS_REQ, FS_BUF).
- One sub-module: fd_reg, the F/D register with enable and bubble-load (PC_D, instr_D, valid_D, exc_adel_D).
- FSM and skid buffer stay in fetch_unit.

Test Plan:
- Reset, 1-cycle ready, next_pc=PC_F+4 → PC_F sequence 0x3000,0x3004,0x3008; PC_D lags by one cycle; valid_D=1 from the 2nd cycle.
- imem_ready low 2 cycles at PC_F=0x3004 → two bubbles (valid_D=0, instr_D=0); PC_F held at 0x3004; fetch_busy=1 for those cycles.
- stall=1 in the same cycle as imem_ready with word 0x24080005 → enter BUF, imem_req=0. stall drops 3 cycles later → instr_D=0x24080005, PC_D=0x3004.
- next_pc=0x3100 while a branch is in D → PC_F=0x3100 after the delay-slot fetch; PC_D order 0x3008,0x300C,0x3100.
- reset asserted mid-fetch with imem_ready=1 → PC_F=0x3000 immediately (async); valid_D=0; response not loaded.
- FETCH_ALIGN_CHECK_EN defined, next_pc=0x3002 → imem_req=0 that cycle; next cycle exc_adel_D=1, PC_D=0x3002, instr_D=0.
